updown_counter: RTL and testbench

- Modulo-N up/down counter for board-level display and timing use. Drives a 7-bit count, e.g. a 0..99 two-digit display value.
- A 2-bit mode input selects clear, hold, run or preset.
- `roll` flags wrap-around so counters can be cascaded or a tick can be raised.
- Single clock domain; sits between board control logic and display or decade-cascade logic.

---
 rtl/updown_counter.sv | 89 ++++++++
 tb/tb_updown_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Modulo-(MAX+1) up/down counter with a mode select and a registered wrap pulse.
// Define UPDOWN_COUNTER_SAT_EN to saturate at 0/MAX in RUN instead of wrapping.
module updown_counter #(
  parameter int WIDTH = 7,
  parameter int MAX   = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ud,
  input  logic [1:0]       state,
  output logic [WIDTH-1:0] count,
  output logic             roll
);

  typedef enum logic [1:0] {
    CLEAR  = 2'b00,
    HOLD   = 2'b01,
    RUN    = 2'b10,
    PRESET = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  mode_e            mode;
  logic [WIDTH-1:0] count_nxt;
  logic             roll_nxt;

  assign mode = mode_e'(state);

  always_comb begin
    count_nxt = count;
    roll_nxt  = 1'b0;
    case (mode)
      CLEAR:  count_nxt = ZERO_V;
      HOLD:   count_nxt = count;
      PRESET: count_nxt = MAX_V;
      RUN: begin
        if (!ud) begin
          // Out-of-range values recover to the natural restart point without a pulse.
          if (count > MAX_V) begin
            count_nxt = ZERO_V;
          end else if (count == MAX_V) begin
`ifdef UPDOWN_COUNTER_SAT_EN
            count_nxt = MAX_V;
`else
            count_nxt = ZERO_V;
            roll_nxt  = 1'b1;
`endif
          end else begin
            count_nxt = count + ONE_V;
`ifdef UPDOWN_COUNTER_SAT_EN
            roll_nxt  = (count_nxt == MAX_V);
`endif
          end
        end else begin
          if (count > MAX_V) begin
            count_nxt = MAX_V;
          end else if (count == ZERO_V) begin
`ifdef UPDOWN_COUNTER_SAT_EN
            count_nxt = ZERO_V;
`else
            count_nxt = MAX_V;
            roll_nxt  = 1'b1;
`endif
          end else begin
            count_nxt = count - ONE_V;
`ifdef UPDOWN_COUNTER_SAT_EN
            roll_nxt  = (count == ONE_V);
`endif
          end
        end
      end
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      roll  <= 1'b0;
    end else begin
      count <= count_nxt;
      roll  <= roll_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Randomised and directed bench for updown_counter against an arithmetic reference model.
// Honours UPDOWN_COUNTER_SAT_EN the same way as the design.
module tb_updown_counter;

  localparam int WIDTH = 7;
  localparam int MAX   = 99;

  logic             clk;
  logic             rst_n;
  logic             ud;
  logic [1:0]       state;
  logic [WIDTH-1:0] count;
  logic             roll;

  int tests;
  int fails;
  int m_count;
  int m_roll;

  updown_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ud    (ud),
    .state (state),
    .count (count),
    .roll  (roll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: modular arithmetic on plain integers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0;
      m_roll  <= 0;
    end else begin
      case (state)
        2'b00: begin m_count <= 0;       m_roll <= 0; end
        2'b01: begin m_count <= m_count; m_roll <= 0; end
        2'b11: begin m_count <= MAX;     m_roll <= 0; end
        default: begin
`ifdef UPDOWN_COUNTER_SAT_EN
          if (!ud) begin
            m_count <= (m_count + 1 > MAX) ? MAX : m_count + 1;
            m_roll  <= int'(m_count + 1 == MAX);
          end else begin
            m_count <= (m_count == 0) ? 0 : m_count - 1;
            m_roll  <= int'(m_count == 1);
          end
`else
          if (!ud) begin
            m_count <= (m_count + 1) % (MAX + 1);
            m_roll  <= int'(m_count + 1 > MAX);
          end else begin
            m_count <= (m_count + MAX) % (MAX + 1);
            m_roll  <= int'(m_count == 0);
          end
`endif
        end
      endcase
    end
  end

  // Every falling edge: DUT vs model.
  always @(negedge clk) begin
    chk("model_count", int'(count), m_count);
    chk("model_roll",  int'(roll),  m_roll);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_to(input int v);
    state = 2'b00; ud = 1'b0;
    step(1);
    state = 2'b10;
    step(v);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; ud = 1'b0; state = 2'b00;
    step(2);
    chk("reset_count", int'(count), 0);
    chk("reset_roll",  int'(roll),  0);
    rst_n = 1'b1;

    // Up run from clear.
    go_to(99);
    chk("up_at_99", int'(count), 99);
    chk("up_roll_low", int'(roll), 0);
    step(1);
`ifdef UPDOWN_COUNTER_SAT_EN
    chk("sat_up_hold", int'(count), 99);
    chk("sat_up_roll", int'(roll), 0);
`else
    chk("up_wrap_count", int'(count), 0);
    chk("up_wrap_roll", int'(roll), 1);
    step(1);
    chk("up_after_wrap", int'(count), 1);
    chk("up_roll_cleared", int'(roll), 0);
`endif

    // Direction change mid-run.
    go_to(20);
    chk("peak_20", int'(count), 20);
    ud = 1'b1;
    step(1);
    chk("dir_change", int'(count), 19);
    chk("dir_change_roll", int'(roll), 0);
    step(19);
    chk("down_at_0", int'(count), 0);
    step(1);
`ifdef UPDOWN_COUNTER_SAT_EN
    chk("sat_down_hold", int'(count), 0);
    chk("sat_down_roll", int'(roll), 0);
`else
    chk("down_wrap_count", int'(count), 99);
    chk("down_wrap_roll", int'(roll), 1);
`endif

    // Hold, preset, clear.
    go_to(42);
    state = 2'b01;
    step(5);
    chk("hold_42", int'(count), 42);
    chk("hold_roll", int'(roll), 0);
    state = 2'b11;
    step(1);
    chk("preset", int'(count), 99);
    state = 2'b00;
    step(1);
    chk("clear", int'(count), 0);

`ifdef UPDOWN_COUNTER_SAT_EN
    state = 2'b11; step(1);
    state = 2'b10; ud = 1'b1; step(2);
    chk("sat_97", int'(count), 97);
    ud = 1'b0; step(1);
    chk("sat_98", int'(count), 98);
    chk("sat_98_roll", int'(roll), 0);
    step(1);
    chk("sat_99", int'(count), 99);
    chk("sat_99_roll", int'(roll), 1);
    step(2);
    chk("sat_99_hold", int'(count), 99);
    chk("sat_99_hold_roll", int'(roll), 0);
    go_to(1);
    ud = 1'b1; step(1);
    chk("sat_0", int'(count), 0);
    chk("sat_0_roll", int'(roll), 1);
    step(1);
    chk("sat_0_hold_roll", int'(roll), 0);
`endif

    // Asynchronous reset mid-count.
    go_to(37);
    chk("pre_reset_37", int'(count), 37);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_roll",  int'(roll),  0);
    step(3);
    chk("held_in_reset", int'(count), 0);
    rst_n = 1'b1;

    // Random traffic, biased towards RUN so wraps happen.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r < 11)      state = 2'b10;
      else if (r < 13) state = 2'b01;
      else if (r < 14) state = 2'b11;
      else             state = 2'b00;
      if ($urandom_range(0, 7) == 0) ud = ~ud;
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
